// File: rtl/inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | inst_fetch : single-outstanding instruction fetch feeding a decode FIFO |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module inst_fetch #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ROB_jump_judge,
  input  logic [31:0] ROB_pc,
  input  logic        ROB_clear,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_valid,
  input  logic [31:0] MC_inst,
  input  logic        ID_stall,
  output logic        ID_valid,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mc_req_q, mc_req_d;
  logic [31:0]        mc_addr_q, mc_addr_d;
  logic               id_valid_q, id_valid_d;
  logic [31:0]        id_inst_q, id_inst_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic               push_en;
  logic               pop_en;

  logic [31:0]        mem_pc   [QDEPTH];
  logic [31:0]        mem_inst [QDEPTH];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mc_req_d   = 1'b0;
    mc_addr_d  = mc_addr_q;
    id_valid_d = 1'b0;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    push_en    = 1'b0;
    pop_en     = 1'b0;

    if (ROB_jump_judge) begin
      pc_d    = ROB_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = S_REDIRECT;
    end else if (ROB_clear) begin
      // Flush keeps the PC; any outstanding read is simply forgotten.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = S_IDLE;
    end else begin
      pop_en = (count_q != '0) && !ID_stall;
      case (state_q)
        S_IDLE: begin
          if (count_q < C_FULL) begin
            mc_req_d  = 1'b1;
            mc_addr_d = pc_q;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (MC_valid) begin
            push_en = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase

      if (pop_en) begin
        id_valid_d = 1'b1;
        id_pc_d    = mem_pc[head_q];
        id_inst_d  = mem_inst[head_q];
        head_d     = head_q + PTR_W'(1);
      end
      if (push_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    if (rdy && push_en) begin
      mem_pc[tail_q]   <= pc_q;
      mem_inst[tail_q] <= MC_inst;
    end
  end

  assign MC_req   = mc_req_q;
  assign MC_addr  = mc_addr_q;
  assign ID_valid = id_valid_q;
  assign ID_inst  = id_inst_q;
  assign ID_pc    = id_pc_q;

endmodule
`default_nettype wire
